branch_predictor: RTL and testbench

- Parametrised dynamic branch predictor for the 5-stage RV32 pipeline. It holds a direct-mapped BTB with per-entry 2-bit saturating counters.
- IF queries it each cycle with the fetch PC to choose the next PC.
- EX reports resolved branches/jumps for table update and mispredict detection, which drives IF redirect and IF/ID + ID/EX flush.
- Replaces the current always-PC+4 fetch with prediction, flush-on-mispredict, table init sweep and performance counters.

---
 rtl/branch_predictor.sv | 131 +++++++++++++
 tb/tb_branch_predictor.sv | 287 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with 2-bit saturating counters, zero-latency fetch lookup,
// EX-stage update, mispredict/redirect generation and saturating statistics.
module branch_predictor #(
    parameter int XLEN    = 32,
    parameter int ENTRIES = 64,
    parameter int CNT_W   = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clear,
    output logic             ready,
    input  logic [XLEN-1:0]  pc_if,
    output logic             pred_taken,
    output logic [XLEN-1:0]  pred_npc,
    input  logic             upd_valid,
    input  logic [XLEN-1:0]  upd_pc,
    input  logic             upd_is_jump,
    input  logic             upd_taken,
    input  logic [XLEN-1:0]  upd_target,
    input  logic             upd_pred_taken,
    input  logic [XLEN-1:0]  upd_pred_npc,
    output logic             mispredict,
    output logic [XLEN-1:0]  redirect_pc,
    output logic [CNT_W-1:0] branch_cnt,
    output logic [CNT_W-1:0] miss_cnt
);

    localparam int IDX_W = $clog2(ENTRIES);
    localparam int TAG_W = XLEN - IDX_W - 2;
    localparam logic [XLEN-1:0]  PC_STEP  = XLEN'(4);
    localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(ENTRIES - 1);

    typedef enum logic {INIT, RUN} state_e;

    state_e           state_q, state_d;
    logic [IDX_W-1:0] sweep_q, sweep_d;

    logic             valid_mem  [ENTRIES];
    logic [TAG_W-1:0] tag_mem    [ENTRIES];
    logic [XLEN-1:0]  target_mem [ENTRIES];
    logic             jump_mem   [ENTRIES];
    logic [1:0]       ctr_mem    [ENTRIES];

    // The carried direction bit is redundant: the predicted next PC alone decides a mispredict.
    logic unused_pred_taken;
    assign unused_pred_taken = upd_pred_taken;

    always_ff @(posedge clk) begin
        if (rst || clear) begin
            state_q <= INIT;
            sweep_q <= '0;
        end else begin
            state_q <= state_d;
            sweep_q <= sweep_d;
        end
    end

    always_comb begin
        state_d = state_q;
        sweep_d = sweep_q;
        if (state_q == INIT) begin
            sweep_d = sweep_q + 1'b1;
            if (sweep_q == LAST_IDX) begin
                state_d = RUN;
            end
        end
    end

    assign ready = (state_q == RUN);

    logic [IDX_W-1:0] lk_idx;
    logic [TAG_W-1:0] lk_tag;
    logic             lk_hit;

    assign lk_idx     = pc_if[IDX_W+1:2];
    assign lk_tag     = pc_if[XLEN-1:IDX_W+2];
    assign lk_hit     = ready & valid_mem[lk_idx] & (tag_mem[lk_idx] == lk_tag);
    assign pred_taken = lk_hit & (jump_mem[lk_idx] | ctr_mem[lk_idx][1]);
    assign pred_npc   = pred_taken ? target_mem[lk_idx] : pc_if + PC_STEP;

    logic [IDX_W-1:0] up_idx;
    logic [TAG_W-1:0] up_tag;
    logic             up_hit;

    assign up_idx = upd_pc[IDX_W+1:2];
    assign up_tag = upd_pc[XLEN-1:IDX_W+2];
    assign up_hit = valid_mem[up_idx] & (tag_mem[up_idx] == up_tag);

    // NOTE: the table has no reset branch; the INIT sweep clears it, so it can map onto plain RAM.
    always_ff @(posedge clk) begin
        if (state_q == INIT) begin
            valid_mem[sweep_q] <= 1'b0;
            ctr_mem[sweep_q]   <= 2'b01;
        end else if (upd_valid) begin
            if (up_hit) begin
                if (upd_is_jump) begin
                    ctr_mem[up_idx]    <= 2'b11;
                    target_mem[up_idx] <= upd_target;
                end else if (upd_taken) begin
                    if (ctr_mem[up_idx] != 2'b11) ctr_mem[up_idx] <= ctr_mem[up_idx] + 2'b01;
                    target_mem[up_idx] <= upd_target;
                end else if (ctr_mem[up_idx] != 2'b00) begin
                    ctr_mem[up_idx] <= ctr_mem[up_idx] - 2'b01;
                end
            end else if (upd_taken) begin
                valid_mem[up_idx]  <= 1'b1;
                tag_mem[up_idx]    <= up_tag;
                target_mem[up_idx] <= upd_target;
                jump_mem[up_idx]   <= upd_is_jump;
                ctr_mem[up_idx]    <= upd_is_jump ? 2'b11 : 2'b10;
            end
        end
    end

    logic [XLEN-1:0] actual_npc;

    assign actual_npc  = upd_taken ? upd_target : upd_pc + PC_STEP;
    assign mispredict  = upd_valid & (actual_npc != upd_pred_npc);
    assign redirect_pc = actual_npc;

    always_ff @(posedge clk) begin
        if (rst) begin
            branch_cnt <= '0;
            miss_cnt   <= '0;
        end else begin
            if (upd_valid && branch_cnt != '1) branch_cnt <= branch_cnt + 1'b1;
            if (mispredict && miss_cnt != '1) miss_cnt <= miss_cnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_branch_predictor.sv
// Directed plus randomized bench for branch_predictor against a table-level reference model.
module tb_branch_predictor;

    localparam int XLEN    = 32;
    localparam int ENTRIES = 16;

    logic        clk = 1'b0;
    logic        rst, clear, upd_valid, upd_is_jump, upd_taken, upd_pred_taken;
    logic [31:0] pc_if, upd_pc, upd_target, upd_pred_npc;

    logic        ready, pred_taken, mispredict;
    logic [31:0] pred_npc, redirect_pc, branch_cnt, miss_cnt;

    logic        ready4, pred_taken4, mispredict4;
    logic [31:0] pred_npc4, redirect_pc4;
    logic [3:0]  branch_cnt4, miss_cnt4;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(32)) dut (
        .clk(clk), .rst(rst), .clear(clear), .ready(ready),
        .pc_if(pc_if), .pred_taken(pred_taken), .pred_npc(pred_npc),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc),
        .mispredict(mispredict), .redirect_pc(redirect_pc),
        .branch_cnt(branch_cnt), .miss_cnt(miss_cnt)
    );

    branch_predictor #(.XLEN(XLEN), .ENTRIES(ENTRIES), .CNT_W(4)) dut4 (
        .clk(clk), .rst(rst), .clear(clear), .ready(ready4),
        .pc_if(pc_if), .pred_taken(pred_taken4), .pred_npc(pred_npc4),
        .upd_valid(upd_valid), .upd_pc(upd_pc), .upd_is_jump(upd_is_jump),
        .upd_taken(upd_taken), .upd_target(upd_target),
        .upd_pred_taken(upd_pred_taken), .upd_pred_npc(upd_pred_npc),
        .mispredict(mispredict4), .redirect_pc(redirect_pc4),
        .branch_cnt(branch_cnt4), .miss_cnt(miss_cnt4)
    );

    // Reference model: one slot per index, counters kept as plain integers.
    bit          m_ready;
    int          m_left;
    bit          m_valid [ENTRIES];
    logic [31:0] m_tag   [ENTRIES];
    logic [31:0] m_tgt   [ENTRIES];
    bit          m_jump  [ENTRIES];
    int          m_ctr   [ENTRIES];
    longint      m_br, m_miss;

    function automatic int slot(input logic [31:0] pc);
        return int'((pc >> 2) % ENTRIES);
    endfunction

    function automatic bit m_pred(input logic [31:0] pc);
        int i = slot(pc);
        return m_ready && m_valid[i] && (m_tag[i] == (pc >> 6)) && (m_jump[i] || m_ctr[i] >= 2);
    endfunction

    function automatic logic [31:0] m_npc(input logic [31:0] pc);
        if (m_pred(pc)) return m_tgt[slot(pc)];
        return pc + 32'd4;
    endfunction

    function automatic logic [31:0] m_actual();
        return upd_taken ? upd_target : upd_pc + 32'd4;
    endfunction

    function automatic bit m_misp();
        return upd_valid && (m_actual() != upd_pred_npc);
    endfunction

    function automatic logic [31:0] sat(input longint v, input longint lim);
        return 32'(v > lim ? lim : v);
    endfunction

    task automatic m_restart();
        m_ready = 1'b0;
        m_left  = ENTRIES;
        for (int i = 0; i < ENTRIES; i++) m_valid[i] = 1'b0;
    endtask

    task automatic m_update();
        int          i;
        logic [31:0] t;
        bit          hit;
        i   = slot(upd_pc);
        t   = upd_pc >> 6;
        hit = m_valid[i] && (m_tag[i] == t);
        if (hit) begin
            if (upd_is_jump) begin
                m_ctr[i] = 3;
                m_tgt[i] = upd_target;
            end else if (upd_taken) begin
                m_ctr[i] = (m_ctr[i] < 3) ? m_ctr[i] + 1 : 3;
                m_tgt[i] = upd_target;
            end else begin
                m_ctr[i] = (m_ctr[i] > 0) ? m_ctr[i] - 1 : 0;
            end
        end else if (upd_taken) begin
            m_valid[i] = 1'b1;
            m_tag[i]   = t;
            m_tgt[i]   = upd_target;
            m_jump[i]  = upd_is_jump;
            m_ctr[i]   = upd_is_jump ? 3 : 2;
        end
    endtask

    task automatic m_edge();
        if (rst) begin
            m_br   = 0;
            m_miss = 0;
            m_restart();
        end else begin
            if (upd_valid) m_br++;
            if (m_misp()) m_miss++;
            if (clear) begin
                m_restart();
            end else if (!m_ready) begin
                m_left--;
                if (m_left == 0) m_ready = 1'b1;
            end else if (upd_valid) begin
                m_update();
            end
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic settle();
        #2;
        check("ready", 32'(ready), 32'(m_ready));
        check("pred_taken", 32'(pred_taken), 32'(m_pred(pc_if)));
        check("pred_npc", pred_npc, m_npc(pc_if));
        check("mispredict", 32'(mispredict), 32'(m_misp()));
        check("redirect_pc", redirect_pc, m_actual());
        check("branch_cnt", branch_cnt, sat(m_br, 64'hFFFF_FFFF));
        check("miss_cnt", miss_cnt, sat(m_miss, 64'hFFFF_FFFF));
        check("branch_cnt4", 32'(branch_cnt4), sat(m_br, 15));
        check("miss_cnt4", 32'(miss_cnt4), sat(m_miss, 15));
    endtask

    task automatic tick();
        @(posedge clk);
        m_edge();
        #1;
    endtask

    task automatic upd(input logic [31:0] pc, input logic taken, input logic [31:0] tgt,
                       input logic jump, input logic [31:0] pnpc);
        upd_valid      = 1'b1;
        upd_pc         = pc;
        upd_taken      = taken;
        upd_target     = tgt;
        upd_is_jump    = jump;
        upd_pred_npc   = pnpc;
        upd_pred_taken = (pnpc != pc + 32'd4);
    endtask

    function automatic logic [31:0] rand_pc();
        logic [31:0] base;
        if ($urandom_range(0, 9) == 0) return 32'hFFFF_FFFC;
        base = 32'h1000 + 32'($urandom_range(0, 2)) * 32'h40;
        return base + 32'($urandom_range(0, ENTRIES - 1)) * 32'd4 + 32'($urandom_range(0, 3) == 0 ? 2 : 0);
    endfunction

    initial begin
        rst = 1'b1; clear = 1'b0; pc_if = 32'h100;
        upd_valid = 1'b0; upd_pc = '0; upd_is_jump = 1'b0; upd_taken = 1'b0;
        upd_target = '0; upd_pred_taken = 1'b0; upd_pred_npc = '0;
        @(posedge clk);
        m_edge();
        #1;
        settle();
        check("reset_ready", 32'(ready), 32'd0);
        tick();
        rst = 1'b0;

        for (int k = 0; k < ENTRIES; k++) begin
            settle();
            check("init_npc", pred_npc, 32'h104);
            tick();
        end
        settle();
        check("ready_after_sweep", 32'(ready), 32'd1);

        upd(32'h200, 1'b1, 32'h180, 1'b0, 32'h204);
        settle();
        check("first_misp", 32'(mispredict), 32'd1);
        check("first_redirect", redirect_pc, 32'h180);
        tick();
        upd_valid = 1'b0; pc_if = 32'h200;
        settle();
        check("alloc_taken", 32'(pred_taken), 32'd1);
        check("alloc_npc", pred_npc, 32'h180);

        upd(32'h200, 1'b0, 32'h0, 1'b0, 32'h180);
        settle(); tick();
        settle(); tick();
        upd_valid = 1'b0;
        settle();
        check("ctr0_npc", pred_npc, 32'h204);
        upd(32'h200, 1'b1, 32'h180, 1'b0, 32'h204);
        settle(); tick();
        upd_valid = 1'b0;
        settle();
        check("ctr1_not_taken", 32'(pred_taken), 32'd0);

        upd(32'h300, 1'b1, 32'h400, 1'b1, 32'h304);
        settle(); tick();
        upd(32'h340, 1'b1, 32'h500, 1'b0, 32'h344);
        settle(); tick();
        upd_valid = 1'b0; pc_if = 32'h300;
        settle();
        check("alias_evicted", pred_npc, 32'h304);
        pc_if = 32'h340;
        settle();
        check("alias_hit", pred_npc, 32'h500);
        tick();

        upd(32'h340, 1'b0, 32'h0, 1'b0, 32'h500);
        settle();
        check("rbw_old", pred_npc, 32'h500);
        tick();
        upd_valid = 1'b0;
        settle();
        check("rbw_new", pred_npc, 32'h344);

        clear = 1'b1;
        settle(); tick();
        clear = 1'b0;
        for (int k = 0; k < ENTRIES; k++) begin
            settle();
            check("clear_not_ready", 32'(ready), 32'd0);
            tick();
        end
        settle();
        check("clear_ready", 32'(ready), 32'd1);
        check("clear_miss", pred_npc, 32'h344);
        check("stats_kept_br", branch_cnt, 32'd7);
        check("stats_kept_miss", miss_cnt, 32'd7);

        rst = 1'b1;
        settle(); tick();
        rst = 1'b0;
        repeat (5) begin settle(); tick(); end
        rst = 1'b1;
        settle(); tick();
        rst = 1'b0;
        for (int k = 0; k < 20; k++) begin
            upd(32'h800 + 32'(k) * 32'd4, 1'b1, 32'h1000, 1'b0, 32'h0);
            settle(); tick();
        end
        upd_valid = 1'b0;
        settle();
        check("sat_br4", 32'(branch_cnt4), 32'd15);
        check("sat_miss4", 32'(miss_cnt4), 32'd15);
        check("full_br", branch_cnt, 32'd20);
        check("full_miss", miss_cnt, 32'd20);

        for (int k = 0; k < 400; k++) begin
            logic [31:0] p;
            pc_if       = rand_pc();
            p           = rand_pc();
            upd_is_jump = ($urandom_range(0, 3) == 0);
            upd(p, upd_is_jump ? 1'b1 : 1'($urandom_range(0, 1)), rand_pc(), upd_is_jump,
                $urandom_range(0, 1) ? m_npc(p) : p + 32'd4);
            upd_valid = ($urandom_range(0, 9) < 7);
            clear     = ($urandom_range(0, 99) == 0);
            settle(); tick();
        end
        clear = 1'b0; upd_valid = 1'b0;
        settle();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
